// File: rtl/hwce_types.sv
// Shared types for the HWCE sum-of-products accumulate controller.
//   state_t   : sequencer states IDLE / ACC / OUT
//   acc_t     : accumulator type at the default partial-sum width
//   red_width : width at which a beat reduction is computed exactly
package hwce_types;

  localparam int unsigned NB_TRELLIS_DFLT = 3;
  localparam int unsigned SUM_WIDHT_DFLT  = 37;
  localparam int unsigned CNT_WIDTH_DFLT  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  typedef logic signed [SUM_WIDHT_DFLT-1:0] acc_t;

  // Exact width of a sum of nb signed w-bit terms (with one guard bit).
  function automatic int unsigned red_width(input int unsigned nb, input int unsigned w);
    return w + int'($clog2(nb)) + 1;
  endfunction

endpackage

// File: rtl/hwce_sop_acc_ctrl_if.sv
// Bundle between the trellis array / output buffer and the SoP accumulate
// controller.
//   cfg_*      : job configuration, sampled with cfg_start
//   in_*       : partial-sum beat stream (valid/ready)
//   out_*      : reduced result stream (valid/ready)
//   ovf/busy/done : job status
// master = producer/consumer side, slave = controller side.
interface hwce_sop_acc_ctrl_if #(
  parameter int unsigned NB_TRELLIS = 3,
  parameter int unsigned SUM_WIDHT  = 37,
  parameter int unsigned CNT_WIDTH  = 16
) ();

  logic                              cfg_start;
  logic [CNT_WIDTH-1:0]              cfg_len;
  logic                              cfg_use_bias;
  logic signed [SUM_WIDHT-1:0]       cfg_bias;

  logic                              in_valid;
  logic                              in_ready;
  logic [NB_TRELLIS*SUM_WIDHT-1:0]   in_data;

  logic                              out_valid;
  logic                              out_ready;
  logic signed [SUM_WIDHT-1:0]       out_data;

  logic                              ovf;
  logic                              busy;
  logic                              done;

  modport master (
    output cfg_start, cfg_len, cfg_use_bias, cfg_bias,
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, ovf, busy, done
  );

  modport slave (
    input  cfg_start, cfg_len, cfg_use_bias, cfg_bias,
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, ovf, busy, done
  );

endinterface

// File: rtl/hwce_sop_add.sv
// Combinational reduction of NB_TRELLIS partial sums into one value,
// wrapping modulo 2^SUM_WIDHT.
//   data : NB_TRELLIS packed partial sums, element 0 in the LSBs
//   sum  : wrapped sum of all elements
// USE_ADDER_TREE selects a balanced tree (1) or a linear chain (0).
module hwce_sop_add #(
  parameter int unsigned NB_TRELLIS     = 3,
  parameter int unsigned SUM_WIDHT      = 37,
  parameter bit          USE_ADDER_TREE = 1'b1
) (
  input  logic [NB_TRELLIS*SUM_WIDHT-1:0] data,
  output logic signed [SUM_WIDHT-1:0]     sum
);

  if (USE_ADDER_TREE) begin : g_tree
    // Leaves padded with zeros up to the next power of two.
    localparam int unsigned NB_POW2 = 1 << $clog2(NB_TRELLIS);

    logic [SUM_WIDHT-1:0] node [NB_POW2];

    // Pairwise levels fold in place; node[0] ends up holding the total.
    always_comb begin
      for (int i = 0; i < int'(NB_TRELLIS); i++) begin
        node[i] = data[i*SUM_WIDHT +: SUM_WIDHT];
      end
      for (int i = int'(NB_TRELLIS); i < int'(NB_POW2); i++) begin
        node[i] = '0;
      end
      for (int s = 1; s < int'(NB_POW2); s = s * 2) begin
        for (int i = 0; i + s < int'(NB_POW2); i = i + 2 * s) begin
          node[i] = node[i] + node[i+s];
        end
      end
    end

    assign sum = node[0];
  end else begin : g_chain
    logic [SUM_WIDHT-1:0] chain;

    always_comb begin
      chain = '0;
      for (int i = 0; i < int'(NB_TRELLIS); i++) begin
        chain = chain + data[i*SUM_WIDHT +: SUM_WIDHT];
      end
    end

    assign sum = chain;
  end

endmodule

// File: rtl/hwce_sop_acc_ctrl.sv
// Sum-of-products accumulate sequencer for one output pixel lane.
// Accepts cfg_len beats of NB_TRELLIS partial sums, reduces each beat,
// accumulates on top of an optional bias, then presents the result.
//   clk, rst   : clock, synchronous active-high reset
//   bus.cfg_*  : start pulse and job parameters (taken only in IDLE)
//   bus.in_*   : beat stream; in_ready is high exactly in ACC
//   bus.out_*  : result stream; out_valid is high exactly in OUT
//   bus.ovf    : sticky signed overflow of the current job
//   bus.busy   : job in progress (ACC or OUT)
//   bus.done   : one-cycle pulse on the result handshake
module hwce_sop_acc_ctrl
  import hwce_types::*;
#(
  parameter int unsigned NB_TRELLIS = 3,
  parameter int unsigned SUM_WIDHT  = 37,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  hwce_sop_acc_ctrl_if.slave bus
);

  localparam int unsigned WIDE_W = red_width(NB_TRELLIS, SUM_WIDHT);
  // Bits of the exact sum that must all equal the result sign bit.
  localparam int unsigned TOP_W  = WIDE_W - SUM_WIDHT + 1;

  state_t                      state, state_next;
  logic signed [SUM_WIDHT-1:0] acc, acc_next;
  logic [CNT_WIDTH-1:0]        cnt, cnt_next;
  logic                        ovf, ovf_next;

  logic signed [SUM_WIDHT-1:0] beat_sum;
  logic signed [SUM_WIDHT-1:0] acc_sum;
  logic signed [WIDE_W-1:0]    wide_sum;
  logic [TOP_W-1:0]            wide_top;
  logic                        red_ovf;
  logic                        add_ovf;
  logic                        beat_fire;

  // Wrapped beat reduction.
  hwce_sop_add #(
    .NB_TRELLIS     (NB_TRELLIS),
    .SUM_WIDHT      (SUM_WIDHT),
    .USE_ADDER_TREE (1'b1)
  ) u_sop_add (
    .data (bus.in_data),
    .sum  (beat_sum)
  );

  // Exact-width reduction used only to detect that the wrapped sum lost bits.
  always_comb begin
    wide_sum = '0;
    for (int i = 0; i < int'(NB_TRELLIS); i++) begin
      wide_sum = wide_sum + WIDE_W'($signed(bus.in_data[i*SUM_WIDHT +: SUM_WIDHT]));
    end
  end

  assign wide_top = wide_sum[WIDE_W-1:SUM_WIDHT-1];
  assign red_ovf  = (|wide_top) && !(&wide_top);

  // Accumulate add; signed overflow when like-signed operands flip sign.
  assign acc_sum = acc + beat_sum;
  assign add_ovf = (acc[SUM_WIDHT-1] == beat_sum[SUM_WIDHT-1]) &&
                   (acc_sum[SUM_WIDHT-1] != acc[SUM_WIDHT-1]);

  assign beat_fire = (state == ACC) && bus.in_valid;

  // Next-state and datapath update.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;
    ovf_next   = ovf;

    case (state)
      IDLE: begin
        if (bus.cfg_start) begin
          acc_next   = bus.cfg_use_bias ? bus.cfg_bias : '0;
          cnt_next   = bus.cfg_len;
          ovf_next   = 1'b0;
          state_next = (bus.cfg_len == '0) ? OUT : ACC;
        end
      end

      ACC: begin
        if (beat_fire) begin
          acc_next = acc_sum;
          cnt_next = cnt - CNT_WIDTH'(1);
          ovf_next = ovf | red_ovf | add_ovf;
          if (cnt == CNT_WIDTH'(1)) begin
            state_next = OUT;
          end
        end
      end

      OUT: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      cnt   <= cnt_next;
      ovf   <= ovf_next;
    end
  end

  // Handshake/status decode straight from registered state.
  assign bus.in_ready  = (state == ACC);
  assign bus.out_valid = (state == OUT);
  assign bus.out_data  = acc;
  assign bus.ovf       = ovf;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == OUT) && bus.out_ready;

endmodule
